// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
//   Bundles the signals between the multicycle control unit and its datapath.
//
//   Instruction/status fields (datapath -> control unit):
//     Cond[3:0], ALUFlags[3:0] (N,Z,C,V), Op[1:0], Funct[5:0], Rd[3:0]
//   Control outputs (control unit -> datapath):
//     PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc[1:0],
//     ALUSrcA, ALUSrcB[1:0], ImmSrc[1:0], RegSrc[1:0], ALUControl[ALUC_W-1:0],
//     State[3:0] (debug), Undef
//
//   Modports:
//     master - the control unit (drives the enables and mux selects)
//     slave  - the datapath (drives the instruction fields and ALU flags)
//
//   There is no valid/ready handshake: every control output is a
//   level-sensitive per-cycle command, sampled by the datapath on the rising
//   clock edge that ends the cycle in which it is asserted.
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
    parameter int ALUC_W = 2
);
    logic [3:0]        Cond;
    logic [3:0]        ALUFlags;
    logic [1:0]        Op;
    logic [5:0]        Funct;
    logic [3:0]        Rd;

    logic              PCWrite;
    logic              AdrSrc;
    logic              MemWrite;
    logic              IRWrite;
    logic              RegWrite;
    logic [1:0]        ResultSrc;
    logic              ALUSrcA;
    logic [1:0]        ALUSrcB;
    logic [1:0]        ImmSrc;
    logic [1:0]        RegSrc;
    logic [ALUC_W-1:0] ALUControl;
    logic [3:0]        State;
    logic              Undef;

    modport master (
        input  Cond, ALUFlags, Op, Funct, Rd,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State, Undef
    );

    modport slave (
        output Cond, ALUFlags, Op, Funct, Rd,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State, Undef
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//   Control unit for a multicycle ARM-subset datapath. A single FSM sequences
//   FETCH / DECODE / execute / memory / writeback so that one ALU and one
//   memory are shared. The NZCV flag register and conditional-execution logic
//   live here.
//
//   Parameters:
//     ALUC_W     - ALUControl width. 2: ADD=00 SUB=01 AND=10 ORR=11.
//                  3: additionally EOR=100, MOV=101.
//     FETCH_WAIT - extra FETCH cycles for slow instruction memory (0..15).
//
//   Ports:
//     CLK   - clock, all state updates on the rising edge
//     RST_N - asynchronous active-low reset
//     bus   - multicycle_control_unit_if.master (instruction fields in,
//             enables / mux selects / debug State / Undef out)
//
//   Optional feature (macro CU_UNDEF_TRAP_EN):
//     defined   - Op=11 enters TRAP, which holds with all enables low and
//                 Undef=1 until reset.
//     undefined - Op=11 is a no-op that returns to FETCH; Undef is tied 0.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int ALUC_W     = 2,
    parameter int FETCH_WAIT = 0
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    multicycle_control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] ALU_ORR = ALUC_W'(3);
    // EOR/MOV only exist with a 3-bit control; otherwise those opcodes fall
    // back to ADD like any other unsupported command.
    localparam logic [ALUC_W-1:0] ALU_EOR = (ALUC_W >= 3) ? ALUC_W'(4) : ALUC_W'(0);
    localparam logic [ALUC_W-1:0] ALU_MOV = (ALUC_W >= 3) ? ALUC_W'(5) : ALUC_W'(0);

    localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT);

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_cnt_next;
    logic [3:0]        flags;

    logic [3:0]        cmd;
    logic              is_cmp;
    logic              is_arith;
    logic [ALUC_W-1:0] alu_dec;
    logic [1:0]        flag_dec;

    logic              fetch_load;
    logic              reg_w;
    logic              mem_w;
    logic              branch;
    logic [1:0]        flag_w;
    logic              adr_src;
    logic [1:0]        result_src;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic [ALUC_W-1:0] alu_ctrl;
    logic              cond_ex;
`ifdef CU_UNDEF_TRAP_EN
    logic              undef;
`endif

    // ------------------------------------------------------------------
    // Instruction decode helpers
    // ------------------------------------------------------------------
    assign cmd      = bus.Funct[4:1];
    assign is_cmp   = (cmd == 4'b1010);
    assign is_arith = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;

    always_comb begin
        alu_dec = ALU_ADD;
        case (cmd)
            4'b0100:          alu_dec = ALU_ADD;
            4'b0010, 4'b1010: alu_dec = ALU_SUB;
            4'b0000:          alu_dec = ALU_AND;
            4'b1100:          alu_dec = ALU_ORR;
            4'b0001:          alu_dec = ALU_EOR;
            4'b1101:          alu_dec = ALU_MOV;
            default:          alu_dec = ALU_ADD;
        endcase
    end

    // CMP exists only to set flags, so it writes them regardless of the S bit.
    // C and V are meaningful only for the arithmetic commands.
    always_comb begin
        flag_dec    = 2'b00;
        flag_dec[1] = bus.Funct[0] | is_cmp;
        flag_dec[0] = (bus.Funct[0] | is_cmp) & is_arith;
    end

    // ------------------------------------------------------------------
    // Condition evaluation against the registered flags; flags written by an
    // instruction are only visible to later instructions.
    // ------------------------------------------------------------------
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags;
        cond_ex = 1'b1;
        case (bus.Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // State, fetch wait counter and flag register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Counts FETCH cycles already spent; cleared whenever FETCH is left so
    // every instruction gets the full FETCH_WAIT+1 cycles.
    always_comb begin
        wait_cnt_next = 4'd0;
        if (state == S_FETCH && !fetch_load) begin
            wait_cnt_next = wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags <= 4'b0000;
        end else begin
            if (flag_w[1] && cond_ex) begin
                flags[3:2] <= bus.ALUFlags[3:2];
            end
            if (flag_w[0] && cond_ex) begin
                flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and ungated per-state controls
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        fetch_load = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        flag_w     = 2'b00;
        adr_src    = 1'b0;
        result_src = 2'b10;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_ctrl   = ALU_ADD;
`ifdef CU_UNDEF_TRAP_EN
        undef      = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                if (wait_cnt == WAIT_LAST) begin
                    fetch_load = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.Op)
                    2'b01:   state_next = S_MEMADR;
                    2'b00:   state_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_next = S_BRANCH;
`ifdef CU_UNDEF_TRAP_EN
                    default: state_next = S_TRAP;
`else
                    default: state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b0;
                alu_src_b  = 2'b01;
                state_next = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a  = 1'b0;
                alu_src_b  = 2'b00;
                alu_ctrl   = alu_dec;
                flag_w     = flag_dec;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a  = 1'b0;
                alu_src_b  = 2'b01;
                alu_ctrl   = alu_dec;
                flag_w     = flag_dec;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_w      = ~is_cmp;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b0;
                alu_src_b  = 2'b01;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
`ifdef CU_UNDEF_TRAP_EN
                undef      = 1'b1;
                state_next = S_TRAP;
`else
                state_next = S_FETCH;
`endif
            end
            default: state_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Enables are qualified by RST_N so that nothing is written while
    // reset is held, even with FETCH_WAIT=0 where FETCH would otherwise load.
    // ------------------------------------------------------------------
    assign bus.IRWrite    = RST_N & fetch_load;
    assign bus.RegWrite   = RST_N & reg_w & cond_ex;
    assign bus.MemWrite   = RST_N & mem_w & cond_ex;
    assign bus.PCWrite    = RST_N & (fetch_load
                                     | (branch & cond_ex)
                                     | (reg_w & cond_ex & (bus.Rd == 4'hF)));
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_ctrl;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {(bus.Op == 2'b01), (bus.Op == 2'b10)};
    assign bus.State      = state;
`ifdef CU_UNDEF_TRAP_EN
    assign bus.Undef      = RST_N & undef;
`else
    assign bus.Undef      = 1'b0;
`endif

endmodule
